mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Memory controller on the responder side of the instruction-fetch request interface; it also serves the MEM stage. It owns the single byte-wide synchronous RAM port. It assembles 32-bit instruction words and 1/2/4-byte data accesses one byte per cycle, little-endian. It arbitrates between IF and MEM and returns one-cycle ready pulses.

Parameters:
ADDR_WIDTH, 32, width of all addresses (pc_i, mem_addr_i, ram_a_o).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
if_from_ram_enable_i  in  1  IF requests the word at pc_i
pc_i  in  ADDR_WIDTH  fetch address, word aligned
pc_jump_enable_i  in  1  redirect; aborts any in-flight fetch
is_if_output_o  out  1  port is free for or serving IF (IDLE/IF_RD)
inst_ready_o  out  1  one-cycle pulse, inst_o valid
inst_o  out  32  fetched instruction
mem_req_i  in  1  MEM access request, held until mem_ready_o
mem_we_i  in  1  1 = store, 0 = load
mem_len_i  in  2  bytes: 1, 2 or 3→4 (0 treated as 1)
mem_addr_i  in  ADDR_WIDTH  data address
mem_wdata_i  in  32  store data, low bytes first
mem_ready_o  out  1  one-cycle completion pulse
mem_rdata_o  out  32  load data, zero-extended
ram_din_i  in  8  RAM read byte (valid the cycle after address)
ram_dout_o  out  8  RAM write byte
ram_a_o  out  ADDR_WIDTH  RAM address
ram_wr_o  out  1  RAM write strobe

Behaviour:
- Reset (rst low, async): state IDLE, byte counter 0. All outputs are 0: ram_wr_o, ram_a_o, ram_dout_o, inst_o, inst_ready_o, mem_rdata_o, mem_ready_o. is_if_output_o is 1.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE. All outputs are registered except is_if_output_o, which is (state==IDLE || state==IF_RD).
- IDLE arbitration at each edge, MEM first:
  - mem_req_i with mem_we_i=1 → MEM_WR.
  - mem_req_i with mem_we_i=0 → MEM_RD.
  - Otherwise, if_from_ram_enable_i && !pc_jump_enable_i → IF_RD.
  - Otherwise stay in IDLE.
  - Address and length are latched at acceptance.
- IF_RD:
  - ram_a_o steps pc, pc+1, pc+2, pc+3 on the 4 edges from acceptance (E0..E3).
  - Byte k is captured at E(k+2).
  - At E5: inst_o is set to {b3,b2,b1,b0}, inst_ready_o goes to 1, and the state moves to DONE.
  - pc_jump_enable_i high at any edge in IF_RD → IDLE, captured bytes are discarded, no inst_ready_o pulse.
- MEM_RD, n bytes: same addressing as IF_RD. mem_rdata_o is set and mem_ready_o pulses at E(n+1). Unread upper bytes are 0.
- MEM_WR, n bytes:
  - ram_wr_o=1 with ram_a_o=addr+k and ram_dout_o=wdata[8k+7:8k] during the cycle after E(k).
  - mem_ready_o pulses at E(n); ram_wr_o drops at the same edge.
- DONE: lasts one cycle, with the ready pulse high. All requests are ignored, then → IDLE. Requesters must drop their request on seeing ready.
- Ready pulses are exactly one cycle. inst_ready_o and mem_ready_o are never high together.
- ram_wr_o is 0 in every state except MEM_WR.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- A MEM request arriving during IF_RD waits until the fetch completes or is aborted. pc_jump_enable_i has no effect on MEM states.

Optional Feature:
MEMCTRL_PREEMPT_EN:
- Defined: mem_req_i high at any edge in IF_RD aborts the fetch, with no inst_ready_o pulse, and enters MEM_RD/MEM_WR at that edge. IF re-requests afterwards.
- Undefined: no preemption, as in Behaviour.

Test Plan:
1. Reset then fetch: RAM[0x100..0x103]=13 05 A0 00, request pc=0x100 → inst_ready_o one pulse at E5, inst_o=0x00A00513, ram_wr_o stays 0.
2. Jump abort: fetch pc=0x200, pulse pc_jump_enable_i at E2 → no inst_ready_o. New fetch pc=0x300 accepted next IDLE edge and completes 5 edges later.
3. Store then load: store len=2 addr=0x1000 data=0x0000BEEF → ram_wr_o high 2 cycles (EF@0x1000, BE@0x1001), mem_ready_o at E2. Load len=4 from 0x1000 → mem_rdata_o=0x0000BEEF (RAM preset 0) at E5.
4. Simultaneous requests in IDLE: mem_req_i load len=1 and if_from_ram_enable_i both high → MEM served first, is_if_output_o=0 throughout. Fetch starts the edge after DONE.
5. Async reset mid MEM_WR (rst low between edges) → ram_wr_o=0 and ram_a_o=0 immediately, state IDLE, no ready pulse after release.
6. With MEMCTRL_PREEMPT_EN: store request at E2 of a fetch → fetch aborted, store completes, re-issued fetch returns the correct word. Without the macro, the store waits until after the fetch's DONE.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial responder for instruction fetch and MEM-stage loads/stores on one 8-bit RAM port.
// Optional: define MEMCTRL_PREEMPT_EN to let a MEM request abort an in-flight fetch.
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_from_ram_enable_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  pc_jump_enable_i,
    output logic                  is_if_output_o,
    output logic                  inst_ready_o,
    output logic [31:0]           inst_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_len_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic                  mem_ready_o,
    output logic [31:0]           mem_rdata_o,
    input  logic [7:0]            ram_din_i,
    output logic [7:0]            ram_dout_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic                  ram_wr_o
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t                state, state_d;
    logic [2:0]            cnt, cnt_d;
    logic [2:0]            len, len_d;
    logic [ADDR_WIDTH-1:0] base, base_d;
    logic [31:0]           wdat, wdat_d;
    logic [31:0]           rbuf, rbuf_d;
    logic [31:0]           word;
    logic [31:0]           inst_d, rdata_d;
    logic                  inst_rdy_d, mem_rdy_d, ram_wr_d;
    logic [7:0]            ram_dout_d;
    logic [ADDR_WIDTH-1:0] ram_a_d, step_a;
    logic [1:0]            boff;
    logic                  take_mem, take_if, preempt;

`ifdef MEMCTRL_PREEMPT_EN
    assign preempt = mem_req_i;
`else
    assign preempt = 1'b0;
`endif

    assign is_if_output_o = (state == IDLE) || (state == IF_RD);
    assign step_a         = base + ADDR_WIDTH'(cnt);
    // cnt counts edges since acceptance; the byte arriving now was addressed two edges ago
    assign boff           = cnt[1:0] - 2'd2;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        len_d      = len;
        base_d     = base;
        wdat_d     = wdat;
        rbuf_d     = rbuf;
        inst_d     = inst_o;
        inst_rdy_d = 1'b0;
        rdata_d    = mem_rdata_o;
        mem_rdy_d  = 1'b0;
        ram_a_d    = ram_a_o;
        ram_dout_d = ram_dout_o;
        ram_wr_d   = 1'b0;
        take_mem   = 1'b0;
        take_if    = 1'b0;
        word       = rbuf;
        if (cnt >= 3'd2) word[8*boff +: 8] = ram_din_i;

        case (state)
            IDLE: begin
                if (mem_req_i) take_mem = 1'b1;
                else if (if_from_ram_enable_i && !pc_jump_enable_i) take_if = 1'b1;
            end
            IF_RD, MEM_RD: begin
                if (state == IF_RD && preempt) begin
                    take_mem = 1'b1;
                end else if (state == IF_RD && pc_jump_enable_i) begin
                    state_d = IDLE;
                end else begin
                    if (cnt < len) ram_a_d = step_a;
                    if (cnt == len + 3'd1) begin
                        state_d = DONE;
                        if (state == IF_RD) begin
                            inst_d     = word;
                            inst_rdy_d = 1'b1;
                        end else begin
                            rdata_d    = word;
                            mem_rdy_d  = 1'b1;
                        end
                    end else begin
                        rbuf_d = word;
                        cnt_d  = cnt + 3'd1;
                    end
                end
            end
            MEM_WR: begin
                if (cnt < len) begin
                    ram_wr_d   = 1'b1;
                    ram_a_d    = step_a;
                    ram_dout_d = wdat[8*cnt[1:0] +: 8];
                    cnt_d      = cnt + 3'd1;
                end else begin
                    mem_rdy_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Acceptance issues the first address at the same edge, from IDLE or on preemption
        if (take_mem) begin
            base_d  = mem_addr_i;
            wdat_d  = mem_wdata_i;
            rbuf_d  = '0;
            cnt_d   = 3'd1;
            ram_a_d = mem_addr_i;
            case (mem_len_i)
                2'd2:    len_d = 3'd2;
                2'd3:    len_d = 3'd4;
                default: len_d = 3'd1;
            endcase
            if (mem_we_i) begin
                state_d    = MEM_WR;
                ram_wr_d   = 1'b1;
                ram_dout_d = mem_wdata_i[7:0];
            end else begin
                state_d = MEM_RD;
            end
        end
        if (take_if) begin
            base_d  = pc_i;
            len_d   = 3'd4;
            rbuf_d  = '0;
            cnt_d   = 3'd1;
            ram_a_d = pc_i;
            state_d = IF_RD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            len          <= '0;
            base         <= '0;
            wdat         <= '0;
            rbuf         <= '0;
            inst_o       <= '0;
            inst_ready_o <= 1'b0;
            mem_rdata_o  <= '0;
            mem_ready_o  <= 1'b0;
            ram_a_o      <= '0;
            ram_dout_o   <= '0;
            ram_wr_o     <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            len          <= len_d;
            base         <= base_d;
            wdat         <= wdat_d;
            rbuf         <= rbuf_d;
            inst_o       <= inst_d;
            inst_ready_o <= inst_rdy_d;
            mem_rdata_o  <= rdata_d;
            mem_ready_o  <= mem_rdy_d;
            ram_a_o      <= ram_a_d;
            ram_dout_o   <= ram_dout_d;
            ram_wr_o     <= ram_wr_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a byte-array memory reference model.
`timescale 1ns/1ps
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_en = 1'b0, jump = 1'b0;
    logic [31:0] pc = '0;
    logic        is_if, inst_ready, mem_ready, ram_wr;
    logic [31:0] inst, mem_rdata;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [1:0]  mem_len = '0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [7:0]  ram_din = '0, ram_dout;
    logic [31:0] ram_a;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ram    [logic [31:0]];
    logic [7:0]  shadow [logic [31:0]];
    logic [39:0] wlog   [$];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_from_ram_enable_i(if_en), .pc_i(pc), .pc_jump_enable_i(jump),
        .is_if_output_o(is_if), .inst_ready_o(inst_ready), .inst_o(inst),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_ready_o(mem_ready), .mem_rdata_o(mem_rdata),
        .ram_din_i(ram_din), .ram_dout_o(ram_dout), .ram_a_o(ram_a), .ram_wr_o(ram_wr)
    );

    // synchronous byte RAM: read data appears the cycle after the address
    always @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_a] = ram_dout;
            wlog.push_back({ram_a, ram_dout});
        end
        ram_din <= ram.exists(ram_a) ? ram[ram_a] : 8'h00;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sh(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : 8'h00;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = sh(a + 32'(i));
        return w;
    endfunction

    function automatic int nbytes(input logic [1:0] lc);
        return (lc == 2'd3) ? 4 : ((lc == 2'd2) ? 2 : 1);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            ram[a + 32'(i)]    = w[8*i +: 8];
            shadow[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    // Called #1 after an edge with the controller idle; that next edge is acceptance.
    task automatic do_fetch(input logic [31:0] a);
        int k = 0;
        bit bad = 0;
        logic [31:0] expw = exp_word(a, 4);
        wlog.delete();
        pc = a; if_en = 1'b1;
        @(posedge clk); #1;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (mem_ready) bad = 1;
            if (inst_ready) break;
            if (!is_if) bad = 1;
        end
        check("if_lat", k, 5);
        check("if_data", inst, expw);
        if_en = 1'b0;
        @(posedge clk); #1;
        check("if_pulse", inst_ready, 0);
        check("if_side", {bad, wlog.size() != 0}, 0);
    endtask

    task automatic do_mem(input bit we, input logic [1:0] lc, input logic [31:0] a, input logic [31:0] wd);
        int k = 0;
        bit bad = 0;
        int n = nbytes(lc);
        logic [31:0] expr = exp_word(a, n);
        wlog.delete();
        mem_we = we; mem_len = lc; mem_addr = a; mem_wdata = wd; mem_req = 1'b1;
        @(posedge clk); #1;
        while (k < 40) begin
            if (inst_ready || is_if) bad = 1;
            @(posedge clk); #1;
            k++;
            if (mem_ready) break;
        end
        check(we ? "st_lat" : "ld_lat", k, we ? n : n + 1);
        if (we) begin
            check("st_nwr", wlog.size(), n);
            for (int i = 0; i < n && i < wlog.size(); i++)
                check("st_wr", wlog[i], {a + 32'(i), wd[8*i +: 8]});
            for (int i = 0; i < n; i++) shadow[a + 32'(i)] = wd[8*i +: 8];
        end else begin
            check("ld_data", mem_rdata, expr);
            check("ld_nwr", wlog.size(), 0);
        end
        mem_req = 1'b0;
        @(posedge clk); #1;
        check("mem_pulse", mem_ready, 0);
        check("mem_side", bad, 0);
    endtask

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        return 32'h0000_1000 + 32'($urandom_range(0, 63));
    endfunction

    initial begin
        int k, ie, me;
        bit bad;
        logic [31:0] wd, got_inst;
        bit pre;
`ifdef MEMCTRL_PREEMPT_EN
        pre = 1;
`else
        pre = 0;
`endif
        preload(32'h100, 32'h00A0_0513);
        preload(32'h200, $urandom);
        preload(32'h300, $urandom);
        preload(32'h400, $urandom);
        preload(32'hFFFF_FFFC, $urandom);

        #12;
        check("rst_ram", {ram_wr, ram_a, ram_dout}, 0);
        check("rst_if", {inst_ready, inst}, 0);
        check("rst_mem", {mem_ready, mem_rdata}, 0);
        check("rst_isif", is_if, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        do_fetch(32'h100);
        check("t1_inst", inst, 32'h00A0_0513);

        // fetch aborted by a jump sampled at E2, new fetch accepted at E3
        pc = 32'h200; if_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        jump = 1'b1;
        @(posedge clk); #1;
        check("jmp_noready", {inst_ready, is_if}, 2'b01);
        jump = 1'b0;
        do_fetch(32'h300);

        do_mem(1'b1, 2'd2, 32'h1000, 32'h0000_BEEF);
        do_mem(1'b0, 2'd3, 32'h1000, 32'h0);
        check("t3_rdata", mem_rdata, 32'h0000_BEEF);

        // simultaneous requests: MEM wins, fetch follows after DONE
        mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h100; mem_req = 1'b1;
        pc = 32'h300; if_en = 1'b1; bad = 0;
        @(posedge clk); #1;
        k = 0;
        while (k < 40) begin
            if (is_if || inst_ready) bad = 1;
            @(posedge clk); #1;
            k++;
            if (mem_ready) break;
        end
        check("sim_mlat", k, 2);
        check("sim_mdata", mem_rdata, 32'h13);
        check("sim_isif", bad, 0);
        mem_req = 1'b0;
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (inst_ready) break;
        end
        check("sim_flat", k, 7);
        check("sim_fdata", inst, exp_word(32'h300, 4));
        if_en = 1'b0;
        @(posedge clk); #1;

        // store arriving during a fetch (sampled at E2)
        wd = $urandom;
        wlog.delete();
        pc = 32'h400; if_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h500; mem_wdata = wd; mem_req = 1'b1;
        ie = -1; me = -1; got_inst = '0; bad = 0;
        for (int e = 2; e < 40; e++) begin
            @(posedge clk); #1;
            if (inst_ready && mem_ready) bad = 1;
            if (inst_ready && ie < 0) begin ie = e; got_inst = inst; if_en = 1'b0; end
            if (mem_ready && me < 0) begin me = e; mem_req = 1'b0; end
            if (ie >= 0 && me >= 0) break;
        end
        check("pre_inst_edge", ie, pre ? 11 : 5);
        check("pre_mem_edge", me, pre ? 4 : 9);
        check("pre_inst", got_inst, exp_word(32'h400, 4));
        check("pre_both", bad, 0);
        check("pre_nwr", wlog.size(), 2);
        shadow[32'h500] = wd[7:0];
        shadow[32'h501] = wd[15:8];
        if_en = 1'b0; mem_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_mem(1'b0, 2'd2, 32'h500, 32'h0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0:       do_fetch(pick_addr() & 32'hFFFF_FFFC);
                1:       do_mem(1'b0, 2'($urandom_range(0, 3)), pick_addr(), 32'h0);
                default: do_mem(1'b1, 2'($urandom_range(0, 3)), pick_addr(), $urandom);
            endcase
        end

        // asynchronous reset in the middle of a store
        mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h3000; mem_wdata = 32'h1234_5678; mem_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("ar_ram", {ram_wr, ram_a}, 0);
        check("ar_isif", {is_if, mem_ready}, 2'b10);
        mem_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        bad = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (mem_ready || inst_ready || ram_wr || !is_if) bad = 1;
        end
        check("ar_quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
